ercm8_share_arb: RTL and testbench

- Shares one combinational ERCM8-class 8x8 approximate multiplier (16-bit product, 7-bit mask input) between NREQ requesters.
- Each requester issues operand/mask requests over a valid/ready handshake.
- The block arbitrates round-robin, registers the winning operands in front of the multiplier, captures the product into a one-entry output buffer and returns it tagged with the requester ID under backpressure.
- Sits between the requesting datapath clients and the multiplier instance; the multiplier itself lives outside this block.

---
 rtl/ercm8_share_arb.sv | 163 ++++++++++++++++
 tb/tb_ercm8_share_arb.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ercm8_share_arb.sv
// ---------------------------------------------------------------------------
// ercm8_share_arb
//   Shares one external combinational ERCM8-class 8x8 approximate multiplier
//   between NREQ requesters. Requests are picked round-robin. The winning
//   operands are registered in S1, and S1 drives the multiplier. The product
//   is then captured in a one-entry output buffer (S2) and returned with the
//   ID of the requester that issued it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     per-requester handshake (at most one ready bit high)
//   req_a/req_b         packed 8-bit operands, requester i at [8i+7:8i]
//   req_mask            packed 7-bit masks, requester i at [7i+6:7i]
//   mul_a/mul_b/mul_mask  S1 operands to the multiplier
//   mul_p               multiplier product (combinational from mul_*)
//   rsp_valid/ready     response handshake
//   rsp_id/rsp_dat      requester index and product of the response
//   busy                S1 or S2 holds an operation
//   op_cnt              completed response handshakes, wraps
// ---------------------------------------------------------------------------
module ercm8_share_arb #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    input  logic [7*NREQ-1:0]   req_mask,
    output logic [7:0]          mul_a,
    output logic [7:0]          mul_b,
    output logic [6:0]          mul_mask,
    input  logic [15:0]         mul_p,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         rsp_dat,
    output logic                busy,
    output logic [CNT_W-1:0]    op_cnt
);

    // S1: operand stage in front of the multiplier
    logic               r_s1_v;
    logic [7:0]         r_s1_a;
    logic [7:0]         r_s1_b;
    logic [6:0]         r_s1_mask;
    logic [ID_W-1:0]    r_s1_id;

    // S2: response buffer
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [15:0]        r_rsp_dat;

    logic [CNT_W-1:0]   r_op_cnt;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_rsp_hs;
    logic               w_s2_adv;
    logic               w_s1_free;
    logic               w_win_found;
    logic [ID_W-1:0]    w_win_id;
    logic               w_accept;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [7:0]         w_win_a;
    logic [7:0]         w_win_b;
    logic [6:0]         w_win_mask;
    int                 w_idx;

    assign w_rsp_hs  = r_rsp_valid & rsp_ready;
    assign w_s2_adv  = r_s1_v & (~r_rsp_valid | rsp_ready);
    assign w_s1_free = ~r_s1_v | w_s2_adv;

    // Round-robin search starting at r_rr_ptr, wrapping at NREQ-1.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_win_found && req_valid[w_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = ID_W'(w_idx);
            end
        end
    end

    // rst_n gates the grant so req_ready reads 0 while reset is held, even
    // though S1 is empty then and would otherwise look free.
    assign w_accept = w_win_found & w_s1_free & rst_n;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept & (int'(w_win_id) == i);
        end
    end

    always_comb begin
        w_win_a    = req_a[int'(w_win_id)*8 +: 8];
        w_win_b    = req_b[int'(w_win_id)*8 +: 8];
        w_win_mask = req_mask[int'(w_win_id)*7 +: 7];
    end

    assign w_ptr_nxt = (int'(w_win_id) == NREQ - 1) ? '0 : w_win_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v      <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_mask   <= '0;
            r_s1_id     <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_v    <= 1'b1;
                r_s1_a    <= w_win_a;
                r_s1_b    <= w_win_b;
                r_s1_mask <= w_win_mask;
                r_s1_id   <= w_win_id;
                r_rr_ptr  <= w_ptr_nxt;
            end else if (w_s2_adv) begin
                r_s1_v    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_dat   <= '0;
            r_op_cnt    <= '0;
        end else begin
            if (w_s2_adv) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_s1_id;
                r_rsp_dat   <= mul_p;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_rsp_hs) begin
                r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
        end
    end

    assign mul_a     = r_s1_a;
    assign mul_b     = r_s1_b;
    assign mul_mask  = r_s1_mask;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_dat   = r_rsp_dat;
    assign busy      = r_s1_v | r_rsp_valid;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_ercm8_share_arb.sv
// ---------------------------------------------------------------------------
// tb_ercm8_share_arb
//   Directed bench for ercm8_share_arb. It uses an occupancy/queue model of the
//   two-deep pipeline, checked every cycle, plus hand-computed literal
//   expectations per scenario.
//   The multiplier stand-in is an exact product with the low 7 bits cleared
//   wherever the mask bit is 0, so the mask path is observable.
// ---------------------------------------------------------------------------
module tb_ercm8_share_arb;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_a = '0;
    logic [8*NREQ-1:0]   req_b = '0;
    logic [7*NREQ-1:0]   req_mask = '0;
    logic [7:0]          mul_a;
    logic [7:0]          mul_b;
    logic [6:0]          mul_mask;
    logic [15:0]         mul_p;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [ID_W-1:0]     rsp_id;
    logic [15:0]         rsp_dat;
    logic                busy;
    logic [CNT_W-1:0]    op_cnt;

    ercm8_share_arb #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mask  (req_mask),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_mask  (mul_mask),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dat   (rsp_dat),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mulf(logic [7:0] a, logic [7:0] b, logic [6:0] m);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        return p & {9'h1FF, m};
    endfunction

    assign mul_p = mulf(mul_a, mul_b, mul_mask);

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] m;
    } op_t;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [6:0]  m;
        logic [15:0] p;
        bit          vis;
    } ent_t;

    op_t  drvq [NREQ][$];
    ent_t mq [$];
    int   m_ptr = 0;
    int   m_cnt = 0;

    int   cyc = 0;
    int   acc_cnt = 0;
    int   grants [$];
    int   grant_cyc [$];
    int   obs_id [$];
    int   obs_dat [$];

    always @(posedge clk) cyc++;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (drvq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_a[8*i +: 8]    = drvq[i][0].a;
                req_b[8*i +: 8]    = drvq[i][0].b;
                req_mask[7*i +: 7] = drvq[i][0].m;
            end else begin
                req_valid[i]       = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_op(int r, logic [7:0] a, logic [7:0] b, logic [6:0] m);
        op_t o;
        o.a = a;
        o.b = b;
        o.m = m;
        drvq[r].push_back(o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) drvq[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        acc_cnt = 0;
        grants.delete();
        grant_cyc.delete();
        obs_id.delete();
        obs_dat.delete();
    endtask

    // Per-cycle model check plus monitors. Inputs are driven 1 time unit
    // after the rising edge, so at the falling edge they show exactly what
    // the next rising edge will sample.
    ent_t            tmp [$];
    ent_t            e;
    bit              m_rv;
    bit              m_hs;
    bit              m_acc_ok;
    bit              m_found;
    int              m_win;
    int              m_idx;
    logic [NREQ-1:0] exp_rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ptr = 0;
            m_cnt = 0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_op_cnt", op_cnt, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_mul_mask", mul_mask, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_dat", rsp_dat, 0);
        end else begin
            m_rv = (mq.size() > 0) && mq[0].vis;
            chk("rsp_valid", rsp_valid, m_rv);
            if (m_rv) begin
                chk("rsp_id", rsp_id, mq[0].id);
                chk("rsp_dat", rsp_dat, mq[0].p);
            end
            chk("busy", busy, mq.size() > 0);
            chk("op_cnt", op_cnt, m_cnt);
            if (mq.size() > 0 && !mq[mq.size()-1].vis) begin
                chk("mul_a", mul_a, mq[mq.size()-1].a);
                chk("mul_b", mul_b, mq[mq.size()-1].b);
                chk("mul_mask", mul_mask, mq[mq.size()-1].m);
            end

            // Next occupancy: retire the head on handshake, then the waiting
            // operation moves to the output slot if that slot is now empty.
            m_hs = m_rv && rsp_ready;
            tmp = mq;
            if (m_hs) void'(tmp.pop_front());
            if (tmp.size() > 0 && !tmp[0].vis) begin
                e = tmp[0];
                e.vis = 1'b1;
                tmp[0] = e;
            end
            m_acc_ok = (tmp.size() == 0) || tmp[tmp.size()-1].vis;

            m_found = 1'b0;
            m_win = 0;
            for (int k = 0; k < NREQ; k++) begin
                m_idx = (m_ptr + k) % NREQ;
                if (!m_found && req_valid[m_idx]) begin
                    m_found = 1'b1;
                    m_win = m_idx;
                end
            end
            exp_rdy = '0;
            if (m_acc_ok && m_found) exp_rdy[m_win] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);

            if (rsp_valid && rsp_ready) begin
                obs_id.push_back(int'(rsp_id));
                obs_dat.push_back(int'(rsp_dat));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (drvq[i].size() > 0) void'(drvq[i].pop_front());
                    acc_cnt++;
                    grants.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            end

            if (m_acc_ok && m_found) begin
                e.id  = m_win;
                e.a   = req_a[8*m_win +: 8];
                e.b   = req_b[8*m_win +: 8];
                e.m   = req_mask[7*m_win +: 7];
                e.p   = mulf(e.a, e.b, e.m);
                e.vis = 1'b0;
                tmp.push_back(e);
                m_ptr = (m_win + 1) % NREQ;
            end
            if (m_hs) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            mq = tmp;
        end
    end

    int exp_d3 [4] = '{16'h0003, 16'h0006, 16'h000C, 16'h0018};
    int exp_d4 [3] = '{16'h0022, 16'h0063, 16'h00C4};
    int guard;
    int g0;
    int pos;
    bit found2;

    initial begin
        do_reset();

        // Reset with two operations in flight
        rsp_ready = 1'b0;
        clear_obs();
        push_op(0, 8'h05, 8'h07, 7'h7F);
        push_op(1, 8'h09, 8'h03, 7'h70);
        push_op(2, 8'h02, 8'h02, 7'h7F);
        drive();
        repeat (4) tick();
        chk("t1_accepts", acc_cnt, 2);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_dat", rsp_dat, 16'h0023);
        chk("t1_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("t1_rst_rsp_valid", rsp_valid, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_op_cnt", op_cnt, 0);
        chk("t1_rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) drvq[i].delete();
        drive();
        rsp_ready = 1'b1;
        clear_obs();
        repeat (6) tick();
        chk("t1_no_stale", obs_id.size(), 0);

        // Single requester, latency
        do_reset();
        rsp_ready = 1'b1;
        clear_obs();
        push_op(0, 8'h01, 8'hB7, 7'h7F);
        drive();
        tick();
        chk("t2_accepted", acc_cnt, 1);
        @(negedge clk);
        #1;
        chk("t2_lat_early", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("t2_lat_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, 0);
        chk("t2_rsp_dat", rsp_dat, 16'h00B7);
        tick();
        tick();
        chk("t2_op_cnt", op_cnt, 1);
        clear_obs();
        push_op(3, 8'hFF, 8'hFF, 7'h00);
        drive();
        repeat (4) tick();
        chk("t2m_count", obs_id.size(), 1);
        if (obs_id.size() > 0) begin
            chk("t2m_id", obs_id[0], 3);
            chk("t2m_dat", obs_dat[0], 16'hFE00);
        end

        // All requesters continuously valid
        do_reset();
        rsp_ready = 1'b1;
        clear_obs();
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < NREQ; i++)
                push_op(i, 8'(1 << i), 8'h03, 7'h7F);
        drive();
        guard = 0;
        while (obs_id.size() < 8 && guard < 40) begin
            tick();
            guard++;
        end
        chk("t3_count", obs_id.size(), 8);
        chk("t3_op_cnt", op_cnt, 8);
        for (int k = 0; k < 8; k++) begin
            if (k < obs_id.size()) begin
                chk("t3_rsp_id", obs_id[k], k % 4);
                chk("t3_rsp_dat", obs_dat[k], exp_d3[k % 4]);
            end
            if (k < grants.size()) chk("t3_grant", grants[k], k % 4);
            if (k > 0 && k < grant_cyc.size())
                chk("t3_grant_gap", grant_cyc[k] - grant_cyc[k-1], 1);
        end

        // Backpressure
        do_reset();
        rsp_ready = 1'b0;
        clear_obs();
        push_op(0, 8'h11, 8'h02, 7'h7F);
        push_op(1, 8'h21, 8'h03, 7'h7F);
        push_op(2, 8'h31, 8'h04, 7'h7F);
        drive();
        repeat (5) tick();
        chk("t4_accepts", acc_cnt, 2);
        chk("t4_req_ready", req_ready, 0);
        chk("t4_rsp_dat_hold", rsp_dat, 16'h0022);
        chk("t4_rsp_id_hold", rsp_id, 0);
        rsp_ready = 1'b1;
        guard = 0;
        while (obs_id.size() < 3 && guard < 20) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        chk("t4_count", obs_id.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < obs_id.size()) begin
                chk("t4_rsp_id", obs_id[k], k);
                chk("t4_rsp_dat", obs_dat[k], exp_d4[k]);
            end
        end

        // Fairness: requester 2 joins late
        do_reset();
        rsp_ready = 1'b1;
        clear_obs();
        for (int n = 0; n < 30; n++) begin
            push_op(0, 8'(n), 8'h01, 7'h7F);
            push_op(1, 8'(n), 8'h02, 7'h7F);
        end
        drive();
        repeat (10) tick();
        g0 = grants.size();
        push_op(2, 8'h77, 8'h01, 7'h7F);
        drive();
        guard = 0;
        while (drvq[2].size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        pos = 0;
        found2 = 1'b0;
        for (int k = g0; k < grants.size(); k++) begin
            if (!found2) begin
                pos++;
                if (grants[k] == 2) found2 = 1'b1;
            end
        end
        chk("t5_req2_granted", found2, 1);
        chk("t5_within_3", pos <= 3, 1);

        // Counter wrap and busy fall
        do_reset();
        rsp_ready = 1'b1;
        clear_obs();
        for (int n = 0; n < 65536; n++) push_op(0, 8'h00, 8'(n), 7'h7F);
        drive();
        guard = 0;
        while (acc_cnt < 65536 && guard < 70000) begin
            tick();
            guard++;
        end
        chk("t6_accepts", acc_cnt, 65536);
        @(negedge clk);
        #1;
        chk("t6_busy_n1", busy, 1);
        @(negedge clk);
        #1;
        chk("t6_busy_n2", busy, 1);
        @(negedge clk);
        #1;
        chk("t6_busy_fall", busy, 0);
        chk("t6_op_cnt_wrap", op_cnt, 0);
        chk("t6_dat_zero", rsp_dat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
